// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared types, BCD constants and load-digit clamp for the magnetron timer
package mag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    COOK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         DIGIT_W      = 4;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // Saturate one keypad digit to the largest value legal in its position
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// rtl/bcd_mmss_dec.sv - combinational one-second decrement of a BCD mm:ss value
module bcd_mmss_dec
  import mag_pkg::*;
(
  input  logic [15:0] time_in,
  output logic [15:0] time_out,
  output logic        zero
);

  logic [DIGIT_W-1:0] mt, mo, st, so;

  // Ripple borrow from seconds ones up through minutes tens; 00:00 wraps to 99:59
  always_comb begin
    mt = time_in[15:12];
    mo = time_in[11:8];
    st = time_in[7:4];
    so = time_in[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = DIGIT_MAX;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = SEC_TENS_MAX;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = DIGIT_MAX;
          mt = (mt != 4'd0) ? mt - 4'd1 : DIGIT_MAX;
        end
      end
    end
    time_out = {mt, mo, st, so};
    zero     = (time_out == 16'h0000);
  end

endmodule

// File: rtl/mag_timer_ctrl.sv
// rtl/mag_timer_ctrl.sv - magnetron enable latch and 1 Hz BCD cook countdown; optional MAG_BEEP_EN adds beep
module mag_timer_ctrl
  import mag_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int MAX_MIN = 99
`ifdef MAG_BEEP_EN
  , parameter int BEEP_SEC = 3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s,
  input  logic        r,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic        mag_on,
  output logic        time_over,
  output logic [15:0] time_bcd,
`ifdef MAG_BEEP_EN
  output logic        beep,
`endif
  output logic        tick
);

  localparam int         PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  state_t        state, next_state;
  logic [PW-1:0] presc;
  logic          presc_tc, presc_run;
  logic [15:0]   ld_bcd, dec_bcd;
  logic          dec_zero, ld_zero, load_take, dec_en;

  bcd_mmss_dec u_dec (
    .time_in  (time_bcd),
    .time_out (dec_bcd),
    .zero     (dec_zero)
  );

  // Clamp keypad digits per position, then clamp the minutes pair to MAX_MIN
  always_comb begin
    ld_bcd = {clamp_digit(load_bcd[15:12], DIGIT_MAX), clamp_digit(load_bcd[11:8], DIGIT_MAX),
              clamp_digit(load_bcd[7:4], SEC_TENS_MAX), clamp_digit(load_bcd[3:0], DIGIT_MAX)};
    if (ld_bcd[15:8] > {MAX_MT, MAX_MO}) ld_bcd[15:8] = {MAX_MT, MAX_MO};
    ld_zero = (ld_bcd == 16'h0000);
  end

  // In DONE, r takes priority over a simultaneous load
  assign load_take = load && (state != COOK) && !(state == DONE && r);
  assign presc_tc  = (presc == PW'(CLK_HZ - 1));
  assign dec_en    = (state == COOK) && !r && presc_tc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; r beats s everywhere and load beats s in READY
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (load_take) next_state = ld_zero ? IDLE : READY;
      READY: begin
        if (load_take)    next_state = ld_zero ? IDLE : READY;
        else if (s && !r) next_state = COOK;
      end
      COOK: begin
        if (r)                       next_state = (time_bcd == 16'h0000) ? IDLE : READY;
        else if (dec_en && dec_zero) next_state = DONE;
      end
      DONE: begin
        if (r)              next_state = IDLE;
        else if (load_take) next_state = ld_zero ? IDLE : READY;
      end
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs decoded from the current state and time register
  always_comb begin
    time_over = (time_bcd == 16'h0000);
    tick      = dec_en;
  end

  // Magnetron enable lags the state by one clock
  always_ff @(posedge clk) begin
    if (rst) mag_on <= 1'b0;
    else     mag_on <= (state == COOK);
  end

  // Remaining-time register: load when not cooking, decrement on each second
  always_ff @(posedge clk) begin
    if (rst)            time_bcd <= 16'h0000;
    else if (load_take) time_bcd <= ld_bcd;
    else if (dec_en)    time_bcd <= dec_bcd;
  end

  // 1 s prescaler; held at zero while idle so a paused partial second is lost
  always_ff @(posedge clk) begin
    if (rst || !presc_run) presc <= '0;
    else if (presc_tc)     presc <= '0;
    else                   presc <= presc + 1'b1;
  end

`ifdef MAG_BEEP_EN
  localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC + 1) : 1;
  logic [BW-1:0] beep_cnt;

  assign presc_run = (state == COOK) || (state == DONE && beep);

  // Beep starts on entry to DONE and lasts BEEP_SEC prescaler periods; leaving DONE cuts it short
  always_ff @(posedge clk) begin
    if (rst) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if (state == COOK && next_state == DONE) begin
      beep     <= 1'b1;
      beep_cnt <= '0;
    end else if (state != DONE || next_state != DONE) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if (beep && presc_tc) begin
      if (beep_cnt == BW'(BEEP_SEC - 1)) beep <= 1'b0;
      beep_cnt <= beep_cnt + 1'b1;
    end
  end
`else
  assign presc_run = (state == COOK);
`endif

endmodule

// File: tb/tb_mag_timer_ctrl.sv
// tb/tb_mag_timer_ctrl.sv - scoreboard bench for mag_timer_ctrl at CLK_HZ=4
module tb_mag_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s = 1'b0;
  logic        r = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = 16'h0000;
  logic        mag_on, time_over, tick;
  logic [15:0] time_bcd;
`ifdef MAG_BEEP_EN
  logic        beep;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] sb_exp;
  logic        pend = 1'b0;
  int n;

  mag_timer_ctrl #(.CLK_HZ(4), .MAX_MIN(99)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .r         (r),
    .load      (load),
    .load_bcd  (load_bcd),
    .mag_on    (mag_on),
    .time_over (time_over),
    .time_bcd  (time_bcd),
`ifdef MAG_BEEP_EN
    .beep      (beep),
`endif
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_bcd = v;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_s();
    s = 1'b1;
    step();
    s = 1'b0;
  endtask

  task automatic wait_time(input string name, input logic [15:0] v, input int budget);
    int k = 0;
    while (time_bcd !== v && k < budget) begin
      step();
      k++;
    end
    check(name, time_bcd, v);
  endtask

  task automatic wait_mag(input string name, input logic v, input int budget);
    int k = 0;
    while (mag_on !== v && k < budget) begin
      step();
      k++;
    end
    check(name, 16'(mag_on), 16'(v));
  endtask

  // Monitor: the cycle after each tick, the new time must match the scoreboard head
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_tick: got %h expected no tick", time_bcd);
      end else begin
        sb_exp = sb_q.pop_front();
        if (time_bcd !== sb_exp) begin
          errors++;
          $display("FAIL sb_tick: got %h expected %h", time_bcd, sb_exp);
        end
      end
    end
    pend = (tick === 1'b1) && !rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state, then s with zero time is ignored
    step(); step(); step();
    rst = 1'b0;
    step();
    check("rst_time", time_bcd, 16'h0000);
    check("rst_mag", 16'(mag_on), 16'h0);
    check("rst_over", 16'(time_over), 16'h1);
    check("rst_tick", 16'(tick), 16'h0);
    pulse_s(); step(); step();
    check("idle_s_ignored", 16'(mag_on), 16'h0);

    // 00:03 countdown to DONE
    do_load(16'h0003);
    check("load_0003", time_bcd, 16'h0003);
    check("over_low", 16'(time_over), 16'h0);
    sb_q.push_back(16'h0002);
    sb_q.push_back(16'h0001);
    sb_q.push_back(16'h0000);
    pulse_s();
    wait_mag("start_mag", 1'b1, 4);
    wait_time("reach_zero", 16'h0000, 30);
    check("zero_over", 16'(time_over), 16'h1);
    check("zero_mag_lag", 16'(mag_on), 16'h1);
`ifdef MAG_BEEP_EN
    check("beep_rise", 16'(beep), 16'h1);
`endif
    step();
    check("done_mag_off", 16'(mag_on), 16'h0);
`ifdef MAG_BEEP_EN
    n = 1;
    while (beep === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("beep_len", 16'(n), 16'd12);
`endif
    pulse_s(); step(); step();
    check("done_s_ignored", 16'(mag_on), 16'h0);

    // 01:00 with minute borrow, pause and resume
    do_load(16'h0100);
    check("load_0100", time_bcd, 16'h0100);
    sb_q.push_back(16'h0059);
    sb_q.push_back(16'h0058);
    pulse_s();
    wait_time("borrow_0058", 16'h0058, 20);
    r = 1'b1;
    step();
    r = 1'b0;
    wait_mag("pause_mag", 1'b0, 3);
    step(); step(); step(); step(); step();
    check("pause_hold", time_bcd, 16'h0058);
    sb_q.push_back(16'h0057);
    s = 1'b1;
    step();
    s = 1'b0;
    n = 1;
    while (time_bcd !== 16'h0057 && n < 20) begin
      step();
      n++;
    end
    check("resume_period", 16'(n), 16'd5);
    r = 1'b1;
    step();
    r = 1'b0;
    wait_mag("stop_mag", 1'b0, 3);

    // Clamp, s+r in READY, load during COOK
    do_load(16'h9A7F);
    check("clamp_9959", time_bcd, 16'h9959);
    s = 1'b1; r = 1'b1;
    step(); step();
    s = 1'b0; r = 1'b0;
    step(); step();
    check("sr_r_wins", 16'(mag_on), 16'h0);
    sb_q.push_back(16'h9958);
    pulse_s();
    wait_mag("cook2_mag", 1'b1, 4);
    do_load(16'h0005);
    step();
    check("cook_load_ignored", time_bcd, 16'h9959);
    wait_time("dec_9958", 16'h9958, 10);
    r = 1'b1;
    step();
    r = 1'b0;
    wait_mag("stop2_mag", 1'b0, 3);

    // load and s together in READY: load wins, stays off
    load = 1'b1; load_bcd = 16'h0007; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step(); step();
    check("ld_s_time", time_bcd, 16'h0007);
    check("ld_s_off", 16'(mag_on), 16'h0);

    // rst mid-cook at 00:30
    do_load(16'h0030);
    pulse_s();
    wait_mag("cook3_mag", 1'b1, 4);
    rst = 1'b1;
    step();
    check("mid_rst_time", time_bcd, 16'h0000);
    check("mid_rst_mag", 16'(mag_on), 16'h0);
    check("mid_rst_over", 16'(time_over), 16'h1);
    check("mid_rst_tick", 16'(tick), 16'h0);
    rst = 1'b0;
    step();

`ifdef MAG_BEEP_EN
    // load in DONE clears beep on the next edge
    do_load(16'h0001);
    sb_q.push_back(16'h0000);
    pulse_s();
    wait_time("beep2_zero", 16'h0000, 20);
    check("beep2_rise", 16'(beep), 16'h1);
    step();
    do_load(16'h0003);
    check("beep2_clear", 16'(beep), 16'h0);
`endif

    step(); step();
    check("sb_drained", 16'(sb_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
